// File: rtl/demux2_stream_if.sv
// rtl/demux2_stream_if.sv - producer and two-consumer stream bundle for demux2_stream
interface demux2_stream_if #(
  parameter int width = 8,
  parameter int cnt_w = 8
);
  logic             in_valid;
  logic             in_ready;
  logic             in_sel;
  logic [width-1:0] in_data;
  logic             y0_valid;
  logic             y0_ready;
  logic [width-1:0] y0_data;
  logic             y1_valid;
  logic             y1_ready;
  logic [width-1:0] y1_data;
  logic [cnt_w-1:0] cnt0;
  logic [cnt_w-1:0] cnt1;

  modport slave (
    input  in_valid, in_sel, in_data, y0_ready, y1_ready,
    output in_ready, y0_valid, y0_data, y1_valid, y1_data, cnt0, cnt1
  );

  modport master (
    output in_valid, in_sel, in_data, y0_ready, y1_ready,
    input  in_ready, y0_valid, y0_data, y1_valid, y1_data, cnt0, cnt1
  );
endinterface

// File: rtl/demux2_stream.sv
// rtl/demux2_stream.sv - 1-to-2 stream demux with a 2-entry FIFO and pop counter per port
module demux2_stream #(
  parameter int width = 8,
  parameter int cnt_w = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  demux2_stream_if.slave bus
);

  logic [1:0]       occ_q  [2];
  logic [1:0]       occ_d  [2];
  logic [width-1:0] head_q [2];
  logic [width-1:0] head_d [2];
  logic [width-1:0] tail_q [2];
  logic [width-1:0] tail_d [2];
  logic [cnt_w-1:0] cnt_q  [2];
  logic [cnt_w-1:0] cnt_d  [2];
  logic             push   [2];
  logic             pop    [2];
  logic             rdy    [2];

  // No bypass: a FULL port refuses a push even when it is popping this cycle.
  assign bus.in_ready = rst_n & (bus.in_sel ? (occ_q[1] != 2'd2) : (occ_q[0] != 2'd2));

  always_comb begin
    rdy[0] = bus.y0_ready;
    rdy[1] = bus.y1_ready;
    for (int p = 0; p < 2; p++) begin
      push[p]   = bus.in_valid & bus.in_ready & (p[0] ? bus.in_sel : ~bus.in_sel);
      pop[p]    = (occ_q[p] != 2'd0) & rdy[p];
      occ_d[p]  = occ_q[p];
      head_d[p] = head_q[p];
      tail_d[p] = tail_q[p];
      cnt_d[p]  = cnt_q[p];

      case ({push[p], pop[p]})
        2'b10:   occ_d[p] = occ_q[p] + 2'd1;
        2'b01:   occ_d[p] = occ_q[p] - 2'd1;
        default: occ_d[p] = occ_q[p];
      endcase

      // head always holds the oldest entry; tail is only meaningful when FULL
      case (occ_q[p])
        2'd0: begin
          if (push[p]) head_d[p] = bus.in_data;
        end
        2'd1: begin
          if (push[p] && pop[p]) head_d[p] = bus.in_data;
          else if (push[p])      tail_d[p] = bus.in_data;
        end
        default: begin
          if (pop[p]) head_d[p] = tail_q[p];
        end
      endcase

      if (pop[p]) cnt_d[p] = cnt_q[p] + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < 2; p++) begin
        occ_q[p]  <= 2'd0;
        head_q[p] <= '0;
        tail_q[p] <= '0;
        cnt_q[p]  <= '0;
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        occ_q[p]  <= occ_d[p];
        head_q[p] <= head_d[p];
        tail_q[p] <= tail_d[p];
        cnt_q[p]  <= cnt_d[p];
      end
    end
  end

  assign bus.y0_valid = (occ_q[0] != 2'd0);
  assign bus.y0_data  = head_q[0];
  assign bus.cnt0     = cnt_q[0];
  assign bus.y1_valid = (occ_q[1] != 2'd0);
  assign bus.y1_data  = head_q[1];
  assign bus.cnt1     = cnt_q[1];

endmodule

// File: tb/tb_demux2_stream.sv
// tb/tb_demux2_stream.sv - directed table-driven bench for demux2_stream (8-bit and 12-bit builds)
module tb_demux2_stream;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  always #5 clk = ~clk;

  demux2_stream_if #(.width(8),  .cnt_w(8)) ia ();
  demux2_stream_if #(.width(12), .cnt_w(4)) ib ();

  demux2_stream #(.width(8),  .cnt_w(8)) dut_a (.clk(clk), .rst_n(rst_a), .bus(ia.slave));
  demux2_stream #(.width(12), .cnt_w(4)) dut_b (.clk(clk), .rst_n(rst_b), .bus(ib.slave));

  typedef struct packed {
    logic       v;
    logic       s;
    logic [7:0] d;
    logic       r0;
    logic       r1;
    logic       ir;
    logic       y0v;
    logic [7:0] y0d;
    logic       y1v;
    logic [7:0] y1d;
    logic [7:0] c0;
    logic [7:0] c1;
  } vec_t;

  vec_t tbl[$];
  int n_checks = 0;
  int n_fail   = 0;

  logic        s_ir, s_y0v, s_y1v;
  logic [11:0] s_y0d, s_y1d;
  logic [7:0]  s_c0, s_c1;

  function automatic vec_t mk(input logic v, s, input logic [7:0] d, input logic r0, r1, ir,
                              y0v, input logic [7:0] y0d, input logic y1v,
                              input logic [7:0] y1d, c0, c1);
    vec_t t;
    t = '{v:v, s:s, d:d, r0:r0, r1:r1, ir:ir, y0v:y0v, y0d:y0d, y1v:y1v, y1d:y1d, c0:c0, c1:c1};
    return t;
  endfunction

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  task automatic drive(input int which, input logic v, s, input logic [11:0] d,
                       input logic r0, r1);
    if (which == 0) begin
      ia.in_valid = v; ia.in_sel = s; ia.in_data = d[7:0]; ia.y0_ready = r0; ia.y1_ready = r1;
    end else begin
      ib.in_valid = v; ib.in_sel = s; ib.in_data = d; ib.y0_ready = r0; ib.y1_ready = r1;
    end
  endtask

  task automatic sample(input int which);
    if (which == 0) begin
      s_ir = ia.in_ready; s_y0v = ia.y0_valid; s_y1v = ia.y1_valid;
      s_y0d = {4'h0, ia.y0_data}; s_y1d = {4'h0, ia.y1_data};
      s_c0 = ia.cnt0; s_c1 = ia.cnt1;
    end else begin
      s_ir = ib.in_ready; s_y0v = ib.y0_valid; s_y1v = ib.y1_valid;
      s_y0d = ib.y0_data; s_y1d = ib.y1_data;
      s_c0 = {4'h0, ib.cnt0}; s_c1 = {4'h0, ib.cnt1};
    end
  endtask

  task automatic edge_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Row applied at a negedge; in_ready checked before the edge, registered outputs after it.
  task automatic apply(input int which, input int idx, input vec_t t);
    logic [11:0] off;
    logic [7:0]  cmask;
    string       tag;
    off   = (which == 0) ? 12'h000 : 12'hA00;
    cmask = (which == 0) ? 8'hFF : 8'h0F;
    tag   = $sformatf("%s row%0d", (which == 0) ? "w8" : "w12", idx);
    drive(which, t.v, t.s, off | {4'h0, t.d}, t.r0, t.r1);
    #1;
    sample(which);
    chk({tag, " in_ready"}, s_ir, t.ir);
    edge_cycle();
    sample(which);
    chk({tag, " y0_valid"}, s_y0v, t.y0v);
    if (t.y0v) chk({tag, " y0_data"}, s_y0d, off | {4'h0, t.y0d});
    chk({tag, " y1_valid"}, s_y1v, t.y1v);
    if (t.y1v) chk({tag, " y1_data"}, s_y1d, off | {4'h0, t.y1d});
    chk({tag, " cnt0"}, s_c0, t.c0 & cmask);
    chk({tag, " cnt1"}, s_c1, t.c1 & cmask);
  endtask

  task automatic check_reset(input int which);
    sample(which);
    chk("rst in_ready", s_ir, 1'b0);
    chk("rst y0_valid", s_y0v, 1'b0);
    chk("rst y0_data", s_y0d, 12'h0);
    chk("rst y1_valid", s_y1v, 1'b0);
    chk("rst y1_data", s_y1d, 12'h0);
    chk("rst cnt0", s_c0, 8'h0);
    chk("rst cnt1", s_c1, 8'h0);
  endtask

  initial begin
    //              v  s  d      r0 r1 ir y0v y0d    y1v y1d    c0 c1
    tbl.push_back(mk(1, 0, 8'hA5, 0, 0, 1, 1, 8'hA5, 0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 1, 0, 1, 0, 8'h00, 0, 8'h00, 1, 0));
    tbl.push_back(mk(1, 0, 8'h01, 1, 1, 1, 1, 8'h01, 0, 8'h00, 1, 0));
    tbl.push_back(mk(1, 1, 8'h02, 1, 1, 1, 0, 8'h00, 1, 8'h02, 2, 0));
    tbl.push_back(mk(1, 0, 8'h03, 1, 1, 1, 1, 8'h03, 0, 8'h00, 2, 1));
    tbl.push_back(mk(1, 1, 8'h04, 1, 1, 1, 0, 8'h00, 1, 8'h04, 3, 1));
    tbl.push_back(mk(0, 0, 8'h00, 1, 1, 1, 0, 8'h00, 0, 8'h00, 3, 2));
    tbl.push_back(mk(1, 1, 8'h10, 0, 0, 1, 0, 8'h00, 1, 8'h10, 3, 2));
    tbl.push_back(mk(1, 1, 8'h11, 0, 0, 1, 0, 8'h00, 1, 8'h10, 3, 2));
    tbl.push_back(mk(1, 1, 8'h12, 0, 0, 0, 0, 8'h00, 1, 8'h10, 3, 2));
    tbl.push_back(mk(1, 0, 8'hBC, 0, 0, 1, 1, 8'hBC, 1, 8'h10, 3, 2));
    tbl.push_back(mk(1, 1, 8'h12, 0, 1, 0, 1, 8'hBC, 1, 8'h11, 3, 3));
    tbl.push_back(mk(1, 1, 8'h12, 0, 1, 1, 1, 8'hBC, 1, 8'h12, 3, 4));
    tbl.push_back(mk(0, 0, 8'h00, 1, 1, 1, 0, 8'h00, 0, 8'h00, 4, 5));
    tbl.push_back(mk(1, 0, 8'h30, 0, 0, 1, 1, 8'h30, 0, 8'h00, 4, 5));
    tbl.push_back(mk(1, 0, 8'h33, 1, 0, 1, 1, 8'h33, 0, 8'h00, 5, 5));
    tbl.push_back(mk(1, 0, 8'h34, 0, 0, 1, 1, 8'h33, 0, 8'h00, 5, 5));
    tbl.push_back(mk(1, 0, 8'h35, 1, 0, 0, 1, 8'h34, 0, 8'h00, 6, 5));
    tbl.push_back(mk(0, 0, 8'h00, 1, 0, 1, 0, 8'h00, 0, 8'h00, 7, 5));

    rst_a = 1'b0;
    rst_b = 1'b0;
    drive(0, 1'b1, 1'b0, 12'h0FF, 1'b1, 1'b1);
    drive(1, 1'b1, 1'b0, 12'hFFF, 1'b1, 1'b1);
    @(negedge clk);
    @(negedge clk);
    check_reset(0);
    check_reset(1);
    drive(0, 1'b0, 1'b0, 12'h0, 1'b0, 1'b0);
    drive(1, 1'b0, 1'b0, 12'h0, 1'b0, 1'b0);
    rst_a = 1'b1;
    rst_b = 1'b1;

    foreach (tbl[i]) apply(0, i, tbl[i]);
    foreach (tbl[i]) apply(1, i, tbl[i]);

    // 4-bit counter wrap on port 1: edge k performs k-1 pops.
    drive(1, 1'b0, 1'b0, 12'h0, 1'b0, 1'b0);
    rst_b = 1'b0;
    @(negedge clk);
    rst_b = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      drive(1, 1'b1, 1'b1, k[11:0], 1'b0, 1'b1);
      edge_cycle();
      sample(1);
      if (k == 16) chk("wrap cnt1 15", s_c1, 8'd15);
      if (k == 17) chk("wrap cnt1 0", s_c1, 8'd0);
      if (k == 18) begin
        chk("wrap cnt1 1", s_c1, 8'd1);
        chk("wrap y1_valid", s_y1v, 1'b1);
        chk("wrap y1_data", s_y1d, 12'd18);
      end
    end
    drive(1, 1'b0, 1'b0, 12'h0, 1'b0, 1'b1);
    edge_cycle();
    sample(1);
    chk("wrap drain cnt1", s_c1, 8'd2);
    chk("wrap drain y1_valid", s_y1v, 1'b0);

    // Asynchronous reset while port 0 is FULL on the 8-bit build.
    drive(0, 1'b1, 1'b0, 12'h041, 1'b0, 1'b0);
    edge_cycle();
    drive(0, 1'b1, 1'b0, 12'h042, 1'b0, 1'b0);
    edge_cycle();
    drive(0, 1'b1, 1'b0, 12'h043, 1'b1, 1'b0);
    #1;
    sample(0);
    chk("full pop in_ready", s_ir, 1'b0);
    chk("full y0_data", s_y0d, 12'h041);
    #2;
    rst_a = 1'b0;
    #1;
    check_reset(0);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 12'h0, 1'b1, 1'b0);
    rst_a = 1'b1;
    edge_cycle();
    sample(0);
    chk("post-rst y0_valid", s_y0v, 1'b0);
    chk("post-rst cnt0", s_c0, 8'd0);
    drive(0, 1'b1, 1'b0, 12'h055, 1'b0, 1'b0);
    #1;
    sample(0);
    chk("post-rst in_ready", s_ir, 1'b1);
    edge_cycle();
    sample(0);
    chk("post-rst y0_valid new", s_y0v, 1'b1);
    chk("post-rst y0_data new", s_y0d, 12'h055);
    drive(0, 1'b0, 1'b0, 12'h0, 1'b1, 1'b0);
    edge_cycle();
    sample(0);
    chk("post-rst pop y0_valid", s_y0v, 1'b0);
    chk("post-rst pop cnt0", s_c0, 8'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
